// File: rtl/sync_packet_fifo_if.sv
// Stream handshake bundle for sync_packet_fifo.
// The FIFO takes the slave view; producer/consumer logic takes master.
interface sync_packet_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  s_tvalid;
  logic                  s_tready;
  logic [DATA_WIDTH-1:0] s_tdata;
  logic                  s_tlast;
  logic                  m_tvalid;
  logic                  m_tready;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tlast;
  logic [ADDR_WIDTH:0]   level;
  logic [ADDR_WIDTH:0]   pkt_cnt;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  drop;

  modport slave (
    input  s_tvalid, s_tdata, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast,
    output level, pkt_cnt, almost_full,
    output almost_empty, drop
  );

  modport master (
    output s_tvalid, s_tdata, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast,
    input  level, pkt_cnt, almost_full,
    input  almost_empty, drop
  );
endinterface

// File: rtl/sync_packet_fifo.sv
// Single-clock stream FIFO with store-and-forward packet mode,
// fill-level flags and oversize-packet dropping.
module sync_packet_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int PACKET_MODE   = 1,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input logic               s_clk,
  input logic               s_rst_n,
  sync_packet_fifo_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  localparam logic [PW-1:0] L_DEPTH = PW'(DEPTH);
  localparam logic [PW-1:0] L_LASTB = PW'(DEPTH - 1);
  localparam logic [PW-1:0] L_ONE   = PW'(1);
  localparam logic [PW-1:0] L_AF    = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] L_AE    = PW'(AEMPTY_THRESH);
  localparam logic          L_PM    = (PACKET_MODE != 0);

  typedef enum logic {
    ST_ACCEPT,
    ST_DROP
  } state_t;

  state_t                r_state;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_cm_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_pkt_cnt;
  logic                  r_drop;
  logic [DATA_WIDTH:0]   r_mem [DEPTH];

  logic [PW-1:0]         w_wr_used;
  logic [PW-1:0]         w_pend;
  logic [PW-1:0]         w_level;
  logic                  w_s_tready;
  logic                  w_m_tvalid;
  logic                  w_wr_hs;
  logic                  w_rd_hs;
  logic                  w_accept;
  logic                  w_trig;
  logic                  w_store;
  logic                  w_pkt_inc;
  logic                  w_pkt_dec;
  logic [DATA_WIDTH:0]   w_entry;

  assign w_wr_used = r_wr_ptr - r_rd_ptr;
  assign w_pend    = r_wr_ptr - r_cm_ptr;
  assign w_level   = r_cm_ptr - r_rd_ptr;

  // Ready depends only on registered pointers: no ready-to-ready path.
  assign w_s_tready = (r_state == ST_DROP) |
                      (w_wr_used != L_DEPTH);
  assign w_m_tvalid = (r_cm_ptr != r_rd_ptr);

  assign w_wr_hs  = bus.s_tvalid & w_s_tready;
  assign w_rd_hs  = w_m_tvalid & bus.m_tready;
  assign w_accept = w_wr_hs & (r_state == ST_ACCEPT);

  // A packet hitting DEPTH beats without tlast can never commit.
  assign w_trig  = w_accept & L_PM & ~bus.s_tlast &
                   (w_pend == L_LASTB);
  assign w_store = w_accept & ~w_trig;

  assign w_entry   = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  assign w_pkt_inc = w_accept & bus.s_tlast;
  assign w_pkt_dec = w_rd_hs & w_entry[DATA_WIDTH];

  // Payload storage, deliberately without reset.
  always_ff @(posedge s_clk) begin
    if (w_store)
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <=
        {bus.s_tlast, bus.s_tdata};
  end

  // Pointer, packet counter and write-side FSM update.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state   <= ST_ACCEPT;
      r_wr_ptr  <= '0;
      r_cm_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_pkt_cnt <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_drop <= w_trig;
      if (w_rd_hs)
        r_rd_ptr <= r_rd_ptr + L_ONE;
      unique case (r_state)
        ST_ACCEPT: begin
          if (w_trig) begin
            r_wr_ptr <= r_cm_ptr;
            r_state  <= ST_DROP;
          end else if (w_store) begin
            r_wr_ptr <= r_wr_ptr + L_ONE;
            if (!L_PM || bus.s_tlast)
              r_cm_ptr <= r_wr_ptr + L_ONE;
          end
        end
        ST_DROP: begin
          if (w_wr_hs && bus.s_tlast)
            r_state <= ST_ACCEPT;
        end
        default: r_state <= ST_ACCEPT;
      endcase
      unique case ({w_pkt_inc, w_pkt_dec})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + L_ONE;
        2'b01:   r_pkt_cnt <= r_pkt_cnt - L_ONE;
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  assign bus.s_tready     = w_s_tready;
  assign bus.m_tvalid     = w_m_tvalid;
  assign bus.m_tdata      = w_m_tvalid ?
                            w_entry[DATA_WIDTH-1:0] : '0;
  assign bus.m_tlast      = w_m_tvalid & w_entry[DATA_WIDTH];
  assign bus.level        = w_level;
  assign bus.pkt_cnt      = r_pkt_cnt;
  assign bus.almost_full  = (w_wr_used >= L_AF);
  assign bus.almost_empty = (w_level <= L_AE);
  assign bus.drop         = r_drop;
endmodule

// File: tb/tb_sync_packet_fifo.sv
// Bench for sync_packet_fifo: cut-through and packet-mode instances
// driven side by side against a queue-style reference model.
module tb_sync_packet_fifo;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  sync_packet_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if0 ();
  sync_packet_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if1 ();

  sync_packet_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4),
    .PACKET_MODE(0)) dut0 (
    .s_clk(clk), .s_rst_n(rst_n), .bus(if0));
  sync_packet_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4),
    .PACKET_MODE(1)) dut1 (
    .s_clk(clk), .s_rst_n(rst_n), .bus(if1));

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference model: committed beats are [hd,cp), pending beats are
  // [cp,tl); indices are unbounded counters into a 256-slot array.
  logic [8:0] mq [2][256];
  int  hd [2];
  int  cp [2];
  int  tl [2];
  int  acc [2];
  bit  dropping [2];
  bit  edrop [2];

  task automatic model_step(input int k,
    input logic vld, input logic [7:0] dat, input logic lst,
    input logic rdy, input logic srdy, input logic mvld,
    input logic [7:0] mdat, input logic mlst,
    input logic [4:0] lvl, input logic [4:0] pc,
    input logic af, input logic ae, input logic dr);
    int used, com, npk;
    bit e_srdy, e_mvld, wa, ra, nd;
    logic [8:0] hv;
    if (!rst_n) begin
      hd[k] = 0; cp[k] = 0; tl[k] = 0;
      dropping[k] = 0; edrop[k] = 0;
    end
    used = tl[k] - hd[k];
    com  = cp[k] - hd[k];
    npk  = 0;
    for (int j = hd[k]; j < cp[k]; j++)
      npk += int'(mq[k][j % 256][8]);
    e_srdy = dropping[k] || (used < 16);
    e_mvld = (com > 0);
    hv = e_mvld ? mq[k][hd[k] % 256] : 9'h0;
    chk($sformatf("m%0d.s_tready", k), srdy, e_srdy);
    chk($sformatf("m%0d.m_tvalid", k), mvld, e_mvld);
    chk($sformatf("m%0d.m_tdata", k), mdat, hv[7:0]);
    chk($sformatf("m%0d.m_tlast", k), mlst, hv[8]);
    chk($sformatf("m%0d.level", k), lvl, com);
    chk($sformatf("m%0d.pkt_cnt", k), pc, npk);
    chk($sformatf("m%0d.afull", k), af, used >= 14);
    chk($sformatf("m%0d.aempty", k), ae, com <= 1);
    chk($sformatf("m%0d.drop", k), dr, edrop[k]);
    if (!rst_n) return;
    wa = vld && e_srdy;
    ra = e_mvld && rdy;
    nd = 0;
    if (ra) hd[k]++;
    if (wa) begin
      if (dropping[k]) begin
        if (lst) dropping[k] = 0;
      end else if (k == 1 && !lst && (tl[k] - cp[k]) == 15) begin
        tl[k] = cp[k];
        dropping[k] = 1;
        nd = 1;
      end else begin
        mq[k][tl[k] % 256] = {lst, dat};
        tl[k]++;
        acc[k]++;
        if (k == 0 || lst) cp[k] = tl[k];
      end
    end
    edrop[k] = nd;
  endtask

  // Continuous model comparison, sampled away from the active edge.
  always @(negedge clk) begin
    model_step(0, if0.s_tvalid, if0.s_tdata, if0.s_tlast,
      if0.m_tready, if0.s_tready, if0.m_tvalid, if0.m_tdata,
      if0.m_tlast, if0.level, if0.pkt_cnt, if0.almost_full,
      if0.almost_empty, if0.drop);
    model_step(1, if1.s_tvalid, if1.s_tdata, if1.s_tlast,
      if1.m_tready, if1.s_tready, if1.m_tvalid, if1.m_tdata,
      if1.m_tlast, if1.level, if1.pkt_cnt, if1.almost_full,
      if1.almost_empty, if1.drop);
  end

  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic       rdy;
    logic       e_srdy;
    logic       e_mvld;
    logic [7:0] e_mdat;
    logic [4:0] e_lvl;
    logic       e_af;
    logic       e_ae;
  } vec_t;

  vec_t tv [34];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [7:0] d,
                      input logic l, input logic r);
    if0.s_tvalid = v; if0.s_tdata = d;
    if0.s_tlast = l; if0.m_tready = r;
  endtask

  task automatic drv1(input logic v, input logic [7:0] d,
                      input logic l, input logic r);
    if1.s_tvalid = v; if1.s_tdata = d;
    if1.s_tlast = l; if1.m_tready = r;
  endtask

  task automatic chk_rst(input string p, input logic srdy,
    input logic mvld, input logic [7:0] mdat, input logic mlst,
    input logic [4:0] lvl, input logic [4:0] pc,
    input logic af, input logic ae, input logic dr);
    chk({p, ".s_tready"}, srdy, 1'b1);
    chk({p, ".m_tvalid"}, mvld, 1'b0);
    chk({p, ".m_tdata"}, mdat, 8'h0);
    chk({p, ".m_tlast"}, mlst, 1'b0);
    chk({p, ".level"}, lvl, 5'd0);
    chk({p, ".pkt_cnt"}, pc, 5'd0);
    chk({p, ".afull"}, af, 1'b0);
    chk({p, ".aempty"}, ae, 1'b1);
    chk({p, ".drop"}, dr, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx [8];
    int rx_n, ndrop, a0, a1, l;

    // Cut-through fill/drain vectors.
    for (int i = 0; i < 16; i++)
      tv[i] = '{1'b1, 8'(i), 1'b0, 1'b1, i > 0, 8'h00,
                5'(i), i >= 14, i <= 1};
    tv[16] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 8'h00,
               5'd16, 1'b1, 1'b0};
    tv[16].e_srdy = 1'b0;
    for (int j = 0; j < 16; j++) begin
      l = 16 - j;
      tv[17+j] = '{1'b0, 8'h00, 1'b1, j > 0, 1'b1, 8'(j),
                   5'(l), l >= 14, l <= 1};
    end
    tv[33] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00,
               5'd0, 1'b0, 1'b1};

    rst_n = 1'b0;
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    @(negedge clk);
    chk_rst("rst0", if0.s_tready, if0.m_tvalid, if0.m_tdata,
      if0.m_tlast, if0.level, if0.pkt_cnt, if0.almost_full,
      if0.almost_empty, if0.drop);
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 34; i++) begin
      drv0(tv[i].vld, tv[i].dat, 1'b0, tv[i].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d.s_tready", i), if0.s_tready,
          tv[i].e_srdy);
      chk($sformatf("vec%0d.m_tvalid", i), if0.m_tvalid,
          tv[i].e_mvld);
      chk($sformatf("vec%0d.m_tdata", i), if0.m_tdata,
          tv[i].e_mdat);
      chk($sformatf("vec%0d.level", i), if0.level, tv[i].e_lvl);
      chk($sformatf("vec%0d.afull", i), if0.almost_full,
          tv[i].e_af);
      chk($sformatf("vec%0d.aempty", i), if0.almost_empty,
          tv[i].e_ae);
      tick();
    end
    drv0(0, 0, 0, 0);

    // Store-and-forward: nothing visible until tlast commits.
    for (int b = 0; b < 3; b++) begin
      drv1(1, 8'hA1 + 8'(b), b == 2, 0);
      @(negedge clk);
      chk($sformatf("sf.hold%0d", b), if1.m_tvalid, 1'b0);
      tick();
    end
    drv1(0, 0, 0, 0);
    @(negedge clk);
    chk("sf.m_tvalid", if1.m_tvalid, 1'b1);
    chk("sf.pkt_cnt", if1.pkt_cnt, 5'd1);
    chk("sf.level", if1.level, 5'd3);
    tick();
    for (int b = 0; b < 3; b++) begin
      drv1(0, 0, 0, 1);
      @(negedge clk);
      chk($sformatf("sf.data%0d", b), if1.m_tdata, 8'hA1 + 8'(b));
      chk($sformatf("sf.last%0d", b), if1.m_tlast, b == 2);
      tick();
    end
    drv1(0, 0, 0, 0);
    @(negedge clk);
    chk("sf.empty", if1.m_tvalid, 1'b0);
    tick();

    // Oversize: 2-beat packet, then 20 beats without early tlast.
    drv1(1, 8'hB0, 0, 0);
    tick();
    drv1(1, 8'hB1, 1, 0);
    tick();
    rx_n = 0;
    ndrop = 0;
    for (int k = 1; k <= 23; k++) begin
      if (k <= 20) drv1(1, 8'h3F + 8'(k), k == 20, 1);
      else drv1(0, 0, 0, 1);
      @(negedge clk);
      if (if1.drop) ndrop++;
      chk($sformatf("ovs.drop%0d", k), if1.drop, k == 17);
      chk($sformatf("ovs.srdy%0d", k), if1.s_tready, 1'b1);
      if (if1.m_tvalid && rx_n < 8) begin
        rx[rx_n] = if1.m_tdata;
        rx_n++;
      end
      tick();
    end
    drv1(0, 0, 0, 0);
    chk("ovs.ndrop", ndrop, 1);
    chk("ovs.rx_n", rx_n, 2);
    chk("ovs.rx0", rx[0], 8'hB0);
    chk("ovs.rx1", rx[1], 8'hB1);
    @(negedge clk);
    chk("ovs.level", if1.level, 5'd0);
    chk("ovs.pkt_cnt", if1.pkt_cnt, 5'd0);
    tick();
    drv1(1, 8'hC0, 0, 0);
    tick();
    drv1(1, 8'hC1, 1, 0);
    tick();
    drv1(0, 0, 0, 0);
    @(negedge clk);
    chk("rec.level", if1.level, 5'd2);
    chk("rec.pkt_cnt", if1.pkt_cnt, 5'd1);
    tick();
    for (int b = 0; b < 2; b++) begin
      drv1(0, 0, 0, 1);
      @(negedge clk);
      chk($sformatf("rec.data%0d", b), if1.m_tdata, 8'hC0 + 8'(b));
      tick();
    end

    // Exactly DEPTH beats ending in tlast is kept.
    for (int k = 0; k < 16; k++) begin
      drv1(1, 8'h60 + 8'(k), k == 15, 0);
      @(negedge clk);
      chk($sformatf("x16.srdy%0d", k), if1.s_tready, 1'b1);
      tick();
    end
    drv1(0, 0, 0, 0);
    @(negedge clk);
    chk("x16.drop", if1.drop, 1'b0);
    chk("x16.level", if1.level, 5'd16);
    chk("x16.pkt_cnt", if1.pkt_cnt, 5'd1);
    chk("x16.s_tready", if1.s_tready, 1'b0);
    tick();
    for (int k = 0; k < 16; k++) begin
      drv1(0, 0, 0, 1);
      @(negedge clk);
      chk($sformatf("x16.data%0d", k), if1.m_tdata, 8'h60 + 8'(k));
      chk($sformatf("x16.last%0d", k), if1.m_tlast, k == 15);
      tick();
    end
    drv1(0, 0, 0, 0);

    // Full with simultaneous write and read.
    for (int i = 0; i < 16; i++) begin
      drv0(1, 8'h80 + 8'(i), 1, 0);
      tick();
    end
    drv0(1, 8'h90, 1, 1);
    @(negedge clk);
    chk("full.srdy0", if0.s_tready, 1'b0);
    chk("full.level0", if0.level, 5'd16);
    chk("full.pkt0", if0.pkt_cnt, 5'd16);
    tick();
    drv0(1, 8'h91, 1, 1);
    @(negedge clk);
    chk("full.level1", if0.level, 5'd15);
    chk("full.pkt1", if0.pkt_cnt, 5'd15);
    chk("full.srdy1", if0.s_tready, 1'b1);
    chk("full.data1", if0.m_tdata, 8'h81);
    tick();
    drv0(0, 0, 0, 0);
    @(negedge clk);
    chk("full.level2", if0.level, 5'd15);
    chk("full.pkt2", if0.pkt_cnt, 5'd15);
    tick();

    // Asynchronous reset in the middle of a packet.
    for (int i = 0; i < 5; i++) begin
      drv1(1, 8'hD0 + 8'(i), 0, 0);
      tick();
    end
    drv1(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_rst("arst0", if0.s_tready, if0.m_tvalid, if0.m_tdata,
      if0.m_tlast, if0.level, if0.pkt_cnt, if0.almost_full,
      if0.almost_empty, if0.drop);
    chk_rst("arst1", if1.s_tready, if1.m_tvalid, if1.m_tdata,
      if1.m_tlast, if1.level, if1.pkt_cnt, if1.almost_full,
      if1.almost_empty, if1.drop);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv1(1, 8'hE0 + 8'(i), i == 2, 0);
      tick();
    end
    drv1(0, 0, 0, 0);
    @(negedge clk);
    chk("post.level", if1.level, 5'd3);
    chk("post.pkt_cnt", if1.pkt_cnt, 5'd1);
    tick();
    for (int b = 0; b < 3; b++) begin
      drv1(0, 0, 0, 1);
      @(negedge clk);
      chk($sformatf("post.data%0d", b), if1.m_tdata, 8'hE0 + 8'(b));
      tick();
    end

    // Random traffic with wrap-around, checked by the model.
    a0 = acc[0];
    a1 = acc[1];
    for (int c = 0; c < 600; c++) begin
      drv0($urandom % 4 != 0, 8'($urandom), $urandom % 5 == 0,
           $urandom % 3 != 0);
      drv1($urandom % 4 != 0, 8'($urandom), $urandom % 6 == 0,
           $urandom % 3 != 0);
      tick();
    end
    for (int c = 0; c < 40; c++) begin
      drv0(0, 0, 0, 1);
      drv1(0, 0, 0, 1);
      tick();
    end
    chk("rand.beats0", (acc[0] - a0) >= 100, 1'b1);
    chk("rand.beats1", (acc[1] - a1) >= 100, 1'b1);
    chk("rand.drain0", if0.level, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
